// File: rtl/bounded_step_counter.sv
// Loadable step counter with trigger reload, upper bound, and a start/done/ack run handshake.
// IDLE waits for start, COUNT steps on en, DONE holds at LIMIT until ack.
module bounded_step_counter #(
  parameter int WD       = 4,
  parameter int LOAD_VAL = 5,
  parameter int TRIG_VAL = 3,
  parameter int LIMIT    = 10,
  parameter int STEP     = 1,
  parameter int WRAP     = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          en,
  input  logic          clr,
  input  logic          load,
  input  logic [WD-1:0] load_val,
  input  logic          ack,
  output logic [WD-1:0] cnt,
  output logic          busy,
  output logic          done,
  output logic          wrapped
);

  typedef enum logic [1:0] {IDLE = 2'd0, COUNT = 2'd1, DONE = 2'd2} state_t;

  localparam logic [WD-1:0] LOAD_C  = WD'(LOAD_VAL);
  localparam logic [WD-1:0] TRIG_C  = WD'(TRIG_VAL);
  localparam logic [WD-1:0] LIMIT_C = WD'(LIMIT);
  localparam logic [WD:0]   LIMIT_X = (WD+1)'(LIMIT);
  localparam logic [WD:0]   STEP_X  = (WD+1)'(STEP);
  localparam logic          WRAP_EN = (WRAP != 0);

  state_t        state;
  state_t        state_nxt;
  logic [WD-1:0] cnt_nxt;
  logic          wrapped_nxt;

  // One extra bit so cnt+STEP can never overflow before comparing to LIMIT.
  logic [WD:0] sum;
  logic        trig_hit;
  logic        over;
  logic        finish;
  logic        wrap_hit;

  always_comb begin
    sum      = {1'b0, cnt} + STEP_X;
    trig_hit = (cnt == TRIG_C);
    // A load can leave cnt at or above LIMIT; that run ends on its first enabled step.
    over     = ({1'b0, cnt} >= LIMIT_X);
    finish   = !trig_hit && (over || (sum == LIMIT_X) || ((sum > LIMIT_X) && !WRAP_EN));
    wrap_hit = !trig_hit && !over && (sum > LIMIT_X) && WRAP_EN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= LOAD_C;
      wrapped <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      wrapped <= wrapped_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nxt = COUNT;
        COUNT:   if (en && finish) state_nxt = DONE;
        DONE:    if (ack) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_nxt     = cnt;
    wrapped_nxt = 1'b0;
    if (clr) begin
      cnt_nxt = LOAD_C;
    end else begin
      case (state)
        IDLE: begin
          if (load) cnt_nxt = load_val;
        end
        COUNT: begin
          if (en) begin
            if (trig_hit) begin
              cnt_nxt = LOAD_C;
            end else if (finish) begin
              cnt_nxt = LIMIT_C;
            end else if (wrap_hit) begin
              cnt_nxt     = LOAD_C;
              wrapped_nxt = 1'b1;
            end else begin
              cnt_nxt = sum[WD-1:0];
            end
          end
        end
        default: cnt_nxt = cnt;
      endcase
    end
  end

  // busy/done together fully encode the state for observation.
  assign busy = (state == COUNT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_bounded_step_counter.sv
// Directed bench for bounded_step_counter: a vector table on the default configuration plus
// hand sequences for stepping/wrap variants, wide saturation, and mid-run reset.
module tb_bounded_step_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, en, clr, load, ack;
  logic [7:0] load_val;

  logic [3:0] cnt0, cnt1, cnt2;
  logic [7:0] cnt3;
  logic       busy0, done0, wrap0;
  logic       busy1, done1, wrap1;
  logic       busy2, done2, wrap2;
  logic       busy3, done3, wrap3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bounded_step_counter u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .en(en), .clr(clr), .load(load),
    .load_val(load_val[3:0]), .ack(ack), .cnt(cnt0), .busy(busy0), .done(done0), .wrapped(wrap0)
  );

  bounded_step_counter #(.STEP(4), .WRAP(0)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .en(en), .clr(clr), .load(load),
    .load_val(load_val[3:0]), .ack(ack), .cnt(cnt1), .busy(busy1), .done(done1), .wrapped(wrap1)
  );

  bounded_step_counter #(.STEP(4), .WRAP(1)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start), .en(en), .clr(clr), .load(load),
    .load_val(load_val[3:0]), .ack(ack), .cnt(cnt2), .busy(busy2), .done(done2), .wrapped(wrap2)
  );

  bounded_step_counter #(.WD(8), .LIMIT(200), .STEP(7)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start), .en(en), .clr(clr), .load(load),
    .load_val(load_val), .ack(ack), .cnt(cnt3), .busy(busy3), .done(done3), .wrapped(wrap3)
  );

  typedef struct {
    logic       st, en, clr, ld;
    logic [7:0] lv;
    logic       ack;
    int         ecnt;
    logic       ebusy, edone, ewrap;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic st, logic e, logic c, logic ld, logic [7:0] lv, logic a,
                              int ecnt, logic eb, logic ed, logic ew);
    vec_t v;
    v.st = st; v.en = e; v.clr = c; v.ld = ld; v.lv = lv; v.ack = a;
    v.ecnt = ecnt; v.ebusy = eb; v.edone = ed; v.ewrap = ew;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic e, input logic c, input logic ld,
                       input logic [7:0] lv, input logic a);
    start = st; en = e; clr = c; load = ld; load_val = lv; ack = a;
  endtask

  // Apply inputs, let one rising edge pass, then sample 1ns later.
  task automatic apply(input logic st, input logic e, input logic c, input logic ld,
                       input logic [7:0] lv, input logic a);
    drive(st, e, c, ld, lv, a);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c3;
    int s3;
    int exp_c1[4] = '{9, 10, 10, 10};
    int exp_c2[4] = '{9, 5, 9, 5};
    int exp_w2[4] = '{0, 1, 0, 1};

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 8'd0, 0);
    #12;
    chk("reset_cnt", cnt0, 5);
    chk("reset_busy", busy0, 0);
    chk("reset_done", done0, 0);
    chk("reset_wrapped", wrap0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #4;

    // Default configuration: LOAD 5, TRIG 3, LIMIT 10, STEP 1, saturating.
    repeat (3) vecs.push_back(mk(0,0,0,0,8'd0,0, 5,0,0,0));
    vecs.push_back(mk(1,1,0,0,8'd0,0,  5,1,0,0));
    vecs.push_back(mk(0,1,0,0,8'd0,0,  6,1,0,0));
    vecs.push_back(mk(0,1,0,0,8'd0,0,  7,1,0,0));
    vecs.push_back(mk(0,1,0,0,8'd0,0,  8,1,0,0));
    vecs.push_back(mk(0,1,0,0,8'd0,0,  9,1,0,0));
    vecs.push_back(mk(0,1,0,0,8'd0,0, 10,0,1,0));
    vecs.push_back(mk(0,1,0,0,8'd0,0, 10,0,1,0));
    vecs.push_back(mk(0,0,0,0,8'd0,1, 10,0,0,0));
    vecs.push_back(mk(1,1,0,1,8'd3,0,  3,1,0,0));
    vecs.push_back(mk(0,1,0,0,8'd0,0,  5,1,0,0));
    vecs.push_back(mk(0,1,0,0,8'd0,0,  6,1,0,0));
    vecs.push_back(mk(0,1,0,0,8'd0,0,  7,1,0,0));
    vecs.push_back(mk(0,1,0,0,8'd0,0,  8,1,0,0));
    vecs.push_back(mk(0,1,0,0,8'd0,0,  9,1,0,0));
    vecs.push_back(mk(0,1,0,0,8'd0,0, 10,0,1,0));
    vecs.push_back(mk(0,0,0,0,8'd0,1, 10,0,0,0));
    vecs.push_back(mk(1,0,0,0,8'd0,0, 10,1,0,0));
    vecs.push_back(mk(0,1,0,0,8'd0,0, 10,0,1,0));
    vecs.push_back(mk(0,0,0,0,8'd0,1, 10,0,0,0));
    vecs.push_back(mk(0,0,0,1,8'd5,0,  5,0,0,0));
    vecs.push_back(mk(1,0,0,0,8'd0,0,  5,1,0,0));
    vecs.push_back(mk(0,1,0,0,8'd0,0,  6,1,0,0));
    vecs.push_back(mk(0,0,0,0,8'd0,0,  6,1,0,0));
    vecs.push_back(mk(0,0,0,0,8'd0,0,  6,1,0,0));
    vecs.push_back(mk(0,1,0,0,8'd0,0,  7,1,0,0));
    vecs.push_back(mk(1,0,0,0,8'd0,0,  7,1,0,0));
    vecs.push_back(mk(0,1,0,1,8'd2,0,  8,1,0,0));
    vecs.push_back(mk(0,1,1,0,8'd0,0,  5,0,0,0));
    vecs.push_back(mk(0,1,0,0,8'd0,1,  5,0,0,0));
    vecs.push_back(mk(1,1,0,1,8'd12,0,12,1,0,0));
    vecs.push_back(mk(0,1,0,0,8'd0,0, 10,0,1,0));
    vecs.push_back(mk(0,0,1,0,8'd0,0,  5,0,0,0));

    foreach (vecs[i]) begin
      apply(vecs[i].st, vecs[i].en, vecs[i].clr, vecs[i].ld, vecs[i].lv, vecs[i].ack);
      chk($sformatf("vec%0d_cnt", i), cnt0, vecs[i].ecnt);
      chk($sformatf("vec%0d_busy", i), busy0, vecs[i].ebusy);
      chk($sformatf("vec%0d_done", i), done0, vecs[i].edone);
      chk($sformatf("vec%0d_wrapped", i), wrap0, vecs[i].ewrap);
    end

    // STEP=4 saturate/wrap variants and the 8-bit LIMIT=200 STEP=7 run share one enabled run.
    apply(0, 0, 1, 0, 8'd0, 0);
    apply(1, 1, 0, 0, 8'd0, 0);
    chk("step4_start_cnt", cnt1, 5);
    chk("step4_start_busy", busy1, 1);
    chk("wide_start_cnt", cnt3, 5);
    c3 = 5;
    for (int i = 0; i < 30; i++) begin
      apply(0, 1, 0, 0, 8'd0, 0);
      if (i < 4) begin
        chk($sformatf("sat4_cnt%0d", i), cnt1, exp_c1[i]);
        chk($sformatf("sat4_done%0d", i), done1, (i >= 1) ? 1 : 0);
        chk($sformatf("wrap4_cnt%0d", i), cnt2, exp_c2[i]);
        chk($sformatf("wrap4_wrapped%0d", i), wrap2, exp_w2[i]);
        chk($sformatf("wrap4_busy%0d", i), busy2, 1);
      end
      if (c3 == 3) c3 = 5;
      else if (c3 < 200) begin
        s3 = c3 + 7;
        c3 = (s3 >= 200) ? 200 : s3;
      end
      chk($sformatf("wide_cnt%0d", i), cnt3, c3);
      chk($sformatf("wide_done%0d", i), done3, (c3 == 200) ? 1 : 0);
    end

    // Asynchronous reset mid-run at cnt=8.
    apply(0, 0, 1, 0, 8'd0, 0);
    apply(1, 1, 0, 0, 8'd0, 0);
    apply(0, 1, 0, 0, 8'd0, 0);
    apply(0, 1, 0, 0, 8'd0, 0);
    apply(0, 1, 0, 0, 8'd0, 0);
    chk("prereset_cnt", cnt0, 8);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_cnt", cnt0, 5);
    chk("async_rst_busy", busy0, 0);
    chk("async_rst_done", done0, 0);
    @(negedge clk);
    drive(0, 1, 0, 0, 8'd0, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_idle_cnt", cnt0, 5);
    chk("post_rst_idle_busy", busy0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
